// File: rtl/ring_pkg.sv
// Shared ring helpers: FSM state encoding, one-hot rotate functions and one-hot to binary.
// Used by the ring counter, the ring pointer and the round-robin arbiter.
package ring_pkg;

  localparam int RING_MAX_W = 32;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_BUSY = 1'b1;

  typedef enum logic {
    S_IDLE = ST_IDLE,
    S_BUSY = ST_BUSY
  } ring_state_t;

  // Rotate the low w bits of v left by one; bits at and above w are returned as zero.
  function automatic logic [RING_MAX_W-1:0] rotl(input logic [RING_MAX_W-1:0] v, input int w);
    logic [RING_MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < RING_MAX_W - 1; i++) begin
      if (i < w - 1) r[i+1] = v[i];
    end
    r[0] = v[w-1];
    return r;
  endfunction

  function automatic logic [RING_MAX_W-1:0] rotr(input logic [RING_MAX_W-1:0] v, input int w);
    logic [RING_MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < RING_MAX_W - 1; i++) begin
      if (i < w - 1) r[i] = v[i+1];
    end
    r[w-1] = v[0];
    return r;
  endfunction

  function automatic int onehot2bin(input logic [RING_MAX_W-1:0] v);
    int b;
    b = 0;
    for (int i = 0; i < RING_MAX_W; i++) begin
      if (v[i]) b = i;
    end
    return b;
  endfunction

endpackage

// File: rtl/rr_ring_ptr.sv
// One-hot ring pointer register: resets to bit 0, and on adv_en loads the
// supplied grant vector rotated left by one (the requester after the last owner).
module rr_ring_ptr
  import ring_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             adv_en,
  input  logic [WIDTH-1:0] load_gnt,
  output logic [WIDTH-1:0] ptr
);

  localparam logic [WIDTH-1:0] PTR_RST = WIDTH'(1);

  logic [RING_MAX_W-1:0] load_ext;
  logic [RING_MAX_W-1:0] rot_ext;
  logic [WIDTH-1:0]      ptr_next;
  logic                  unused_hi;

  always_comb begin
    load_ext                = '0;
    load_ext[WIDTH-1:0]     = load_gnt;
    rot_ext                 = rotl(load_ext, WIDTH);
    ptr_next                = rot_ext[WIDTH-1:0];
  end

  assign unused_hi = ^rot_ext;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= PTR_RST;
    end else if (adv_en) begin
      ptr <= ptr_next;
    end
  end

endmodule

// File: rtl/ring_rr_arbiter.sv
// Round-robin arbiter driven by a one-hot rotating ring pointer; grants are registered and held
// until the owner drops its request. Optional hold limit: define RR_ARB_HOLD_LIMIT_EN.
module ring_rr_arbiter
  import ring_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int HOLD_MAX = 8,
  localparam int IDX_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] req,
  output logic [WIDTH-1:0] gnt,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_idx,
  output logic [WIDTH-1:0] ptr
);

  ring_state_t           state;
  ring_state_t           state_n;
  logic [WIDTH-1:0]      gnt_n;
  logic                  vld_n;
  logic [IDX_W-1:0]      idx_n;
  logic                  release_own;
  logic                  hold_expired;
  logic                  win_found;
  logic [IDX_W-1:0]      win_idx;
  logic [RING_MAX_W-1:0] ptr_ext;
  int                    base;
  int                    pos;

  // Circular priority scan starting at the pointer bit, inclusive, wrapping upward.
  always_comb begin
    ptr_ext            = '0;
    ptr_ext[WIDTH-1:0] = ptr;
    base               = onehot2bin(ptr_ext);
    pos                = 0;
    win_found          = 1'b0;
    win_idx            = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pos = base + i;
      if (pos >= WIDTH) pos = pos - WIDTH;
      if (!win_found && req[pos]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(pos);
      end
    end
  end

`ifdef RR_ARB_HOLD_LIMIT_EN
  localparam int CNT_W = $clog2(HOLD_MAX + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

  logic [CNT_W-1:0] hold_cnt;

  // hold_cnt reaches HOLD_MAX-1 on the last edge of an HOLD_MAX-cycle grant.
  assign hold_expired = (state == S_BUSY) && (hold_cnt >= HOLD_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_cnt <= '0;
    end else if (state == S_IDLE || release_own) begin
      hold_cnt <= '0;
    end else begin
      hold_cnt <= hold_cnt + CNT_W'(1);
    end
  end
`else
  assign hold_expired = 1'b0;
`endif

  assign release_own = (state == S_BUSY) && (!req[gnt_idx] || hold_expired);

  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    vld_n   = gnt_valid;
    idx_n   = gnt_idx;
    case (state)
      S_IDLE: begin
        if (win_found) begin
          state_n = S_BUSY;
          gnt_n   = WIDTH'(1) << win_idx;
          vld_n   = 1'b1;
          idx_n   = win_idx;
        end
      end
      S_BUSY: begin
        if (release_own) begin
          state_n = S_IDLE;
          gnt_n   = '0;
          vld_n   = 1'b0;
          idx_n   = '0;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Grant register stage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      gnt_idx   <= '0;
    end else begin
      state     <= state_n;
      gnt       <= gnt_n;
      gnt_valid <= vld_n;
      gnt_idx   <= idx_n;
    end
  end

  rr_ring_ptr #(
    .WIDTH(WIDTH)
  ) u_ptr (
    .clk     (clk),
    .reset   (reset),
    .adv_en  (release_own),
    .load_gnt(gnt),
    .ptr     (ptr)
  );

endmodule

// File: tb/tb_ring_rr_arbiter.sv
// Self-checking bench for ring_rr_arbiter (WIDTH=4, HOLD_MAX=8): vector table, hand-written
// corner sequences and a randomized run against a behavioural model, all via a scoreboard queue.
module tb_ring_rr_arbiter;

  localparam int W    = 4;
  localparam int HOLD = 8;

  logic         clk = 1'b0;
  logic         clk_run = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] req = '0;
  logic [W-1:0] gnt;
  logic         gnt_valid;
  logic [1:0]   gnt_idx;
  logic [W-1:0] ptr;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] gnt;
    logic       vld;
    logic [1:0] idx;
    logic [3:0] ptr;
    string      name;
  } exp_t;

  typedef struct {
    logic       rst_before;
    logic [3:0] req;
    logic [3:0] gnt;
    logic       vld;
    logic [1:0] idx;
    logic [3:0] ptr;
  } vec_t;

  exp_t sb[$];

  ring_rr_arbiter #(.WIDTH(W), .HOLD_MAX(HOLD)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .gnt      (gnt),
    .gnt_valid(gnt_valid),
    .gnt_idx  (gnt_idx),
    .ptr      (ptr)
  );

  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  task automatic push_exp(input logic [3:0] g, input logic v, input logic [1:0] i,
                          input logic [3:0] p, input string name);
    exp_t e;
    e.gnt = g; e.vld = v; e.idx = i; e.ptr = p; e.name = name;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard: empty queue at compare, got gnt=%b", gnt);
      return;
    end
    e = sb.pop_front();
    checks++;
    if (gnt !== e.gnt || gnt_valid !== e.vld || gnt_idx !== e.idx || ptr !== e.ptr) begin
      errors++;
      $display("FAIL %s: got gnt=%b vld=%b idx=%0d ptr=%b, expected gnt=%b vld=%b idx=%0d ptr=%b",
               e.name, gnt, gnt_valid, gnt_idx, ptr, e.gnt, e.vld, e.idx, e.ptr);
    end
  endtask

  task automatic step(input logic [3:0] r, input logic [3:0] g, input logic v,
                      input logic [1:0] i, input logic [3:0] p, input string name);
    push_exp(g, v, i, p, name);
    req = r;
    @(posedge clk);
    #1;
    pop_check();
  endtask

  task automatic do_reset();
    req = '0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Behavioural reference state for the randomized run.
  int m_owner;
  int m_ptr;
  int m_cnt;

  task automatic model_step(input logic [3:0] r);
    logic rel;
    if (m_owner < 0) begin
      for (int i = 0; i < W; i++) begin
        int k;
        k = (m_ptr + i) % W;
        if (m_owner < 0 && r[k]) m_owner = k;
      end
      m_cnt = 0;
    end else begin
      rel = !r[m_owner];
`ifdef RR_ARB_HOLD_LIMIT_EN
      if (m_cnt == HOLD - 1) rel = 1'b1;
`endif
      if (rel) begin
        m_ptr   = (m_owner + 1) % W;
        m_owner = -1;
      end else begin
        m_cnt++;
      end
    end
  endtask

  vec_t tbl[22];

  initial begin
    tbl[0]  = '{1'b1, 4'b1010, 4'b0010, 1'b1, 2'd1, 4'b0001};
    tbl[1]  = '{1'b0, 4'b1000, 4'b0000, 1'b0, 2'd0, 4'b0100};
    tbl[2]  = '{1'b0, 4'b1000, 4'b1000, 1'b1, 2'd3, 4'b0100};
    tbl[3]  = '{1'b0, 4'b1000, 4'b1000, 1'b1, 2'd3, 4'b0100};
    tbl[4]  = '{1'b0, 4'b0001, 4'b0000, 1'b0, 2'd0, 4'b0001};
    tbl[5]  = '{1'b0, 4'b0001, 4'b0001, 1'b1, 2'd0, 4'b0001};
    tbl[6]  = '{1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, 4'b0010};
    tbl[7]  = '{1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, 4'b0010};
    tbl[8]  = '{1'b1, 4'b1111, 4'b0001, 1'b1, 2'd0, 4'b0001};
    tbl[9]  = '{1'b0, 4'b1111, 4'b0001, 1'b1, 2'd0, 4'b0001};
    tbl[10] = '{1'b0, 4'b1110, 4'b0000, 1'b0, 2'd0, 4'b0010};
    tbl[11] = '{1'b0, 4'b1111, 4'b0010, 1'b1, 2'd1, 4'b0010};
    tbl[12] = '{1'b0, 4'b1111, 4'b0010, 1'b1, 2'd1, 4'b0010};
    tbl[13] = '{1'b0, 4'b1101, 4'b0000, 1'b0, 2'd0, 4'b0100};
    tbl[14] = '{1'b0, 4'b1111, 4'b0100, 1'b1, 2'd2, 4'b0100};
    tbl[15] = '{1'b0, 4'b1111, 4'b0100, 1'b1, 2'd2, 4'b0100};
    tbl[16] = '{1'b0, 4'b1011, 4'b0000, 1'b0, 2'd0, 4'b1000};
    tbl[17] = '{1'b0, 4'b1111, 4'b1000, 1'b1, 2'd3, 4'b1000};
    tbl[18] = '{1'b0, 4'b1111, 4'b1000, 1'b1, 2'd3, 4'b1000};
    tbl[19] = '{1'b0, 4'b0111, 4'b0000, 1'b0, 2'd0, 4'b0001};
    tbl[20] = '{1'b0, 4'b1111, 4'b0001, 1'b1, 2'd0, 4'b0001};
    tbl[21] = '{1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, 4'b0010};

    // Reset with no clock running
    #2;
    reset = 1'b1;
    push_exp(4'b0000, 1'b0, 2'd0, 4'b0001, "async_reset_no_clk");
    #1;
    pop_check();
    clk_run = 1'b1;
    @(negedge clk);
    reset = 1'b0;

    // Table: basic grant, release, wrap, fairness order
    for (int n = 0; n < 22; n++) begin
      if (tbl[n].rst_before) do_reset();
      step(tbl[n].req, tbl[n].gnt, tbl[n].vld, tbl[n].idx, tbl[n].ptr, $sformatf("table_%0d", n));
    end

    // Asynchronous reset while owner 2 is busy
    do_reset();
    step(4'b0100, 4'b0100, 1'b1, 2'd2, 4'b0001, "busy_owner2");
    @(negedge clk);
    #2;
    reset = 1'b1;
    push_exp(4'b0000, 1'b0, 2'd0, 4'b0001, "reset_mid_busy");
    #1;
    pop_check();
    req = '0;
    @(negedge clk);
    reset = 1'b0;
    step(4'b0000, 4'b0000, 1'b0, 2'd0, 4'b0001, "idle_after_reset");
    step(4'b0010, 4'b0010, 1'b1, 2'd1, 4'b0001, "grant_after_reset");

    // Constant request from requester 0
    do_reset();
`ifdef RR_ARB_HOLD_LIMIT_EN
    for (int c = 1; c <= 12; c++) begin
      if (c <= HOLD)          step(4'b0001, 4'b0001, 1'b1, 2'd0, 4'b0001, $sformatf("hold_lim_%0d", c));
      else if (c == HOLD + 1) step(4'b0001, 4'b0000, 1'b0, 2'd0, 4'b0010, "hold_lim_release");
      else                    step(4'b0001, 4'b0001, 1'b1, 2'd0, 4'b0010, $sformatf("hold_lim_regrant_%0d", c));
    end
`else
    for (int c = 1; c <= 34; c++) begin
      step(4'b0001, 4'b0001, 1'b1, 2'd0, 4'b0001, $sformatf("hold_forever_%0d", c));
    end
`endif

    // Randomized requests against the behavioural model
    do_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_cnt   = 0;
    begin
      logic [3:0] r;
      r = '0;
      for (int c = 0; c < 300; c++) begin
        for (int b = 0; b < W; b++) begin
          if ($urandom_range(3) == 0) r[b] = ~r[b];
        end
        model_step(r);
        step(r,
             (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000,
             (m_owner >= 0),
             (m_owner >= 0) ? 2'(m_owner) : 2'd0,
             4'b0001 << m_ptr,
             $sformatf("random_%0d", c));
      end
    end

    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
